// File: rtl/right_shift_rot_32_pkg.sv
// Shared widths and mode encoding for the 32-bit right shifter/rotator.
package right_shift_rot_32_pkg;
  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;
  localparam logic SHIFT  = 1'b0;
  localparam logic ROTATE = 1'b1;
endpackage

// File: rtl/right_shift_rot_32_stage.sv
// One log-shifter stage: shifts or rotates right by K when enabled, else passes through.
module rsr_stage
  import right_shift_rot_32_pkg::*;
#(
  parameter int K = 1
) (
  input  logic [DATA_W-1:0] data,
  input  logic              enable,
  input  logic              rotate,
  output logic [DATA_W-1:0] result
);

  logic [K-1:0] fill;

  always_comb begin
    fill = (rotate == ROTATE) ? data[K-1:0] : {K{1'b0}};
    if (enable) begin
      result = {fill, data[DATA_W-1:K]};
    end else begin
      result = data;
    end
  end

endmodule

// File: rtl/right_shift_rot_32.sv
// Registered 32-bit right barrel shifter/rotator: five log stages feeding one output register.
module right_shift_rot_32
  import right_shift_rot_32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              rotate,
  input  logic [AMT_W-1:0]  select,
  output logic [DATA_W-1:0] out
);

  // stg[s] is the input to stage s; stg[AMT_W] is the fully shifted word.
  logic [DATA_W-1:0] stg [0:AMT_W];

  assign stg[0] = in;

  for (genvar s = 0; s < AMT_W; s++) begin : g_stage
    rsr_stage #(
      .K(1 << s)
    ) u_stage (
      .data  (stg[s]),
      .enable(select[s]),
      .rotate(rotate),
      .result(stg[s+1])
    );
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= stg[AMT_W];
    end
  end

endmodule

// File: tb/tb_right_shift_rot_32.sv
// Directed bench for right_shift_rot_32: reset behaviour, corner vectors and a full amount/mode sweep.
module tb_right_shift_rot_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] in;
  logic        rotate;
  logic [4:0]  select;
  logic [31:0] out;

  int n_cmp;
  int n_err;

  right_shift_rot_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .rotate(rotate),
    .select(select),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] expected);
    n_cmp++;
    assert (out === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, out, expected);
    end
  endtask

  // Apply inputs away from the active edge, then sample just after the next rising edge.
  task automatic step(input logic [31:0] d, input logic [4:0] amt, input logic rot);
    @(negedge clk);
    in     = d;
    select = amt;
    rotate = rot;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_model(input logic [31:0] d, input int amt, input logic rot);
    logic [63:0] dbl;
    if (rot) dbl = {d, d} >> amt;
    else     dbl = {32'h0, d} >> amt;
    return dbl[31:0];
  endfunction

  initial begin
    logic [31:0] r;
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    in     = 32'h0;
    rotate = 1'b0;
    select = 5'd0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Make out nonzero, then drop reset mid-cycle.
    step(32'hDEAD_BEEF, 5'd0, 1'b0);
    check("pre_reset_load", 32'hDEAD_BEEF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'h0);
    in = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("reset_held_edge", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(32'hFFFF_FFFF, 5'd6, 1'b0);
    check("release_shift6", 32'h03FF_FFFF);

    step(32'h0000_0001, 5'd31, 1'b1);
    check("max_rotate", 32'h0000_0002);

    step(32'h0000_0007, 5'd25, 1'b0);
    check("shift_to_zero", 32'h0000_0000);

    step(32'h0000_0007, 5'd25, 1'b1);
    check("rotate_wrap", 32'h0000_0380);
    step(32'h0000_0007, 5'd25, 1'b0);
    check("mode_toggle", 32'h0000_0000);

    step(32'h8000_0001, 5'd0, 1'b0);
    check("ident_shift", 32'h8000_0001);
    step(32'h8000_0001, 5'd0, 1'b1);
    check("ident_rotate", 32'h8000_0001);
    step(32'h8000_0001, 5'd1, 1'b0);
    check("shift1_no_sign", 32'h4000_0000);
    step(32'h8000_0001, 5'd1, 1'b1);
    check("rotate1", 32'hC000_0000);

    step(32'hF000_0000, 5'd31, 1'b0);
    check("shift31_msb", 32'h0000_0001);
    step(32'h1234_5678, 5'd16, 1'b1);
    check("rotate16", 32'h5678_1234);

    // Input changes between edges must not disturb the registered output.
    #2;
    in     = 32'hFFFF_FFFF;
    select = 5'd3;
    #1;
    check("hold_between_edges", 32'h5678_1234);

    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 32; s++) begin
        r = $urandom;
        step(r, 5'(s), m[0]);
        check($sformatf("sweep_m%0d_s%0d", m, s), ref_model(r, s, m[0]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
